// File: rtl/dm_arb_pkg.sv
// dm_port_arbiter shared types: FSM state encoding and DM geometry.
package dm_arb_pkg;

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } arb_state_e;

  // DM holds 1024 words; word index is byte address [11:2]
  localparam int DM_AW = 10;

endpackage

// File: rtl/dm_arb_age_ctr.sv
// Saturating count of DMA requests denied by CPU priority.
// Only built when DM_ARB_AGE_EN is defined.
module dm_arb_age_ctr #(
  parameter int AGE_LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int CW = $clog2(AGE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(AGE_LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == LIM);

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single-port DM between the CPU M stage and the DMA port.
// Optional DMA aging under `define DM_ARB_AGE_EN.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int AGE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] cpu_pc8,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic        dm_we,
  output logic [31:0] dm_pc8,
  input  logic [31:0] dm_rdata
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] LAST = BW'(MAX_BURST - 1);

  arb_state_e    state, state_n;
  logic [BW-1:0] beat_cnt, beat_cnt_n;
  logic          age_hit;

`ifdef DM_ARB_AGE_EN
  logic age_inc, age_clr;

  assign age_inc = (state == S_CPU) && cpu_req && dma_req;
  assign age_clr = !dma_req ||
                   (state == S_CPU && state_n == S_DMA);

  dm_arb_age_ctr #(
    .AGE_LIMIT(AGE_LIMIT)
  ) u_age (
    .clk  (clk),
    .reset(reset),
    .inc  (age_inc),
    .clr  (age_clr),
    .hit  (age_hit)
  );
`else
  // No aging: CPU priority is absolute
  assign age_hit = (AGE_LIMIT < 0);
`endif

  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    dm_addr    = cpu_addr;
    dm_wd      = cpu_wdata;
    dm_we      = cpu_req & cpu_we;
    dm_pc8     = cpu_pc8;
    cpu_stall  = 1'b0;
    dma_gnt    = 1'b0;
    case (state)
      S_CPU: begin
        if (dma_req && (!cpu_req || age_hit)) begin
          state_n    = S_DMA;
          beat_cnt_n = '0;
        end
      end
      S_DMA: begin
        dm_addr   = dma_addr;
        dm_wd     = dma_wdata;
        dm_we     = dma_req & dma_we;
        dm_pc8    = '0;
        dma_gnt   = dma_req;
        cpu_stall = cpu_req;
        if (!dma_req) begin
          state_n = S_CPU;
        end else begin
          beat_cnt_n = beat_cnt + 1'b1;
          if (beat_cnt == LAST) state_n = S_CPU;
        end
      end
      default: state_n = S_CPU;
    endcase
    // Never commit a write while reset is held
    if (reset) dm_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_CPU;
      beat_cnt   <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      state      <= state_n;
      beat_cnt   <= beat_cnt_n;
      dma_rvalid <= dma_gnt & ~dma_we;
      if (dma_gnt && !dma_we) dma_rdata <= dm_rdata;
    end
  end

  assign cpu_rdata = dm_rdata;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural 1024-word DM.
// Aging check follows DM_ARB_AGE_EN.
module tb_dm_port_arbiter;
  import dm_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_pc8;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic [31:0] dm_addr, dm_wd, dm_pc8, dm_rdata;
  logic        dm_we;

  logic [31:0] mem [0:(1<<DM_AW)-1];

  int total = 0;
  int bad = 0;
  int gcnt;

  always #5 clk = ~clk;

  dm_port_arbiter #(
    .MAX_BURST(8),
    .AGE_LIMIT(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_pc8   (cpu_pc8),
    .cpu_stall (cpu_stall),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_gnt   (dma_gnt),
    .dma_rvalid(dma_rvalid),
    .dma_rdata (dma_rdata),
    .dm_addr   (dm_addr),
    .dm_wd     (dm_wd),
    .dm_we     (dm_we),
    .dm_pc8    (dm_pc8),
    .dm_rdata  (dm_rdata)
  );

  assign dm_rdata = mem[dm_addr[DM_AW+1:2]];

  always @(posedge clk)
    if (dm_we) mem[dm_addr[DM_AW+1:2]] <= dm_wd;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic r, input logic w,
                         input logic [31:0] a,
                         input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    cpu_pc8 = a + 32'h100;
  endtask

  task automatic dma_set(input logic r, input logic w,
                         input logic [31:0] a,
                         input logic [31:0] d);
    dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    for (int i = 0; i < (1<<DM_AW); i++) mem[i] = '0;
    reset = 1'b1;
    cpu_set(1'b1, 1'b1, 32'h40, 32'hBAD0BAD0);
    dma_set(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(); cyc();
    #1;
    chk("rst_dm_we", dm_we, 1'b0);
    chk("rst_rvalid", dma_rvalid, 1'b0);
    chk("rst_rdata", dma_rdata, 32'h0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_gnt", dma_gnt, 1'b0);

    // CPU store then load
    cyc();
    reset = 1'b0;
    chk("rst_no_write", mem[32'h40 >> 2], 32'h0);
    cpu_set(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    chk("cpu_dm_we", dm_we, 1'b1);
    chk("cpu_dm_addr", dm_addr, 32'h10);
    chk("cpu_dm_wd", dm_wd, 32'hDEADBEEF);
    chk("cpu_dm_pc8", dm_pc8, 32'h110);
    chk("cpu_stall0", cpu_stall, 1'b0);
    cyc();
    cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    chk("cpu_load", cpu_rdata, 32'hDEADBEEF);
    chk("cpu_load_we", dm_we, 1'b0);
    cyc();
    cpu_set(1'b1, 1'b1, 32'h20, 32'h12345678);
    cyc();
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);

    // DMA 3-beat write burst
    dma_set(1'b1, 1'b1, 32'h0, 32'hA0);
    #1;
    chk("ho_gnt", dma_gnt, 1'b0);
    chk("ho_we", dm_we, 1'b0);
    for (int b = 0; b < 3; b++) begin
      cyc();
      dma_set(1'b1, 1'b1, 32'(b*4), 32'hA0 + 32'(b));
      #1;
      chk("bur_gnt", dma_gnt, 1'b1);
      chk("bur_we", dm_we, 1'b1);
      chk("bur_addr", dm_addr, 32'(b*4));
      chk("bur_pc8", dm_pc8, 32'h0);
    end
    cyc();
    dma_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("bur_end_gnt", dma_gnt, 1'b0);
    cyc();
    cpu_set(1'b1, 1'b0, 32'h4, 32'h0);
    #1;
    chk("bur_back_stall", cpu_stall, 1'b0);
    chk("bur_data1", cpu_rdata, 32'hA1);
    chk("bur_data2", mem[2], 32'hA2);

    // DMA read
    cyc();
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dma_set(1'b1, 1'b0, 32'h20, 32'h0);
    cyc();
    #1;
    chk("rd_gnt", dma_gnt, 1'b1);
    chk("rd_rvalid_pre", dma_rvalid, 1'b0);
    cyc();
    dma_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rd_rvalid", dma_rvalid, 1'b1);
    chk("rd_rdata", dma_rdata, 32'h12345678);
    cyc();
    chk("rd_rvalid_drop", dma_rvalid, 1'b0);
    chk("rd_rdata_hold", dma_rdata, 32'h12345678);

    // Burst cap with CPU load raised mid-burst
    dma_set(1'b1, 1'b1, 32'h100, 32'h500);
    #1;
    chk("cap_ho_gnt", dma_gnt, 1'b0);
    for (int b = 0; b < 8; b++) begin
      cyc();
      dma_set(1'b1, 1'b1, 32'h100 + 32'(b*4), 32'h500 + 32'(b));
      if (b == 3) cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
      #1;
      chk("cap_gnt", dma_gnt, 1'b1);
      chk("cap_stall", cpu_stall, (b >= 3));
    end
    cyc();
    chk("cap_exit_gnt", dma_gnt, 1'b0);
    chk("cap_exit_stall", cpu_stall, 1'b0);
    chk("cap_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("cap_last_beat", mem[(32'h100 >> 2) + 7], 32'h507);
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("cap_reho_gnt", dma_gnt, 1'b0);
    cyc();
    chk("cap_reenter_gnt", dma_gnt, 1'b1);
    dma_set(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();

    // Reset in the 3rd beat of a burst
    dma_set(1'b1, 1'b1, 32'h200, 32'h77);
    cyc();
    cyc();
    dma_set(1'b1, 1'b1, 32'h204, 32'h78);
    cyc();
    dma_set(1'b1, 1'b1, 32'h208, 32'h79);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", dm_we, 1'b0);
    cyc();
    reset = 1'b0;
    #1;
    chk("mid_rst_gnt", dma_gnt, 1'b0);
    chk("mid_rst_rvalid", dma_rvalid, 1'b0);
    chk("mid_rst_nowr", mem[32'h208 >> 2], 32'h0);
    chk("mid_rst_beat2", mem[32'h204 >> 2], 32'h78);
    dma_set(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();

    // Contention: CPU and DMA both high continuously
    cpu_set(1'b1, 1'b0, 32'h10, 32'h0);
    dma_set(1'b1, 1'b0, 32'h20, 32'h0);
    gcnt = 0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (dma_gnt) gcnt++;
      cyc();
    end
`ifdef DM_ARB_AGE_EN
    chk("age_forced_gnt", 32'(gcnt > 0), 32'd1);
`else
    chk("starve_gnt", 32'(gcnt), 32'd0);
`endif
    cpu_set(1'b0, 1'b0, 32'h0, 32'h0);
    dma_set(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single-port word data memory between the CPU M-stage port and a DMA/debug loader port.
- Combinationally muxes the owner's address, write data, write enable and pc8 onto the DM.
- Stalls the CPU while DMA owns the memory; DMA bursts are capped in length.
- Sits between the M-stage pipeline register, the DMA engine and the DM block. CPU has priority by default.

Parameters:
- MAX_BURST, 8, max consecutive DMA beats per ownership period (>=1).
- AGE_LIMIT, 16, cycles of denied DMA requests before a forced DMA grant (used only with DM_ARB_AGE_EN).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cpu_req  in  1  M stage issues a load or store this cycle
- cpu_we  in  1  store when 1
- cpu_addr  in  32  byte address; bits [1:0] ignored by DM
- cpu_wdata  in  32  store data
- cpu_pc8  in  32  PC+8 of the M-stage instruction
- cpu_stall  out  1  freeze F/D/E/M stages
- cpu_rdata  out  32  load data, combinational
- dma_req  in  1  DMA beat request
- dma_we  in  1  DMA write when 1
- dma_addr  in  32  DMA byte address
- dma_wdata  in  32  DMA write data
- dma_gnt  out  1  DMA beat accepted this cycle
- dma_rvalid  out  1  registered read data valid
- dma_rdata  out  32  registered read data
- dm_addr  out  32  to DM
- dm_wd  out  32  to DM
- dm_we  out  1  to DM write enable
- dm_pc8  out  32  to DM, used for the trace
- dm_rdata  in  32  from DM, combinational read

Behaviour:
- State machine S_CPU / S_DMA. Beat counter width is clog2(MAX_BURST)+1.
- Reset values: state=S_CPU, beat_cnt=0, dma_rvalid=0, dma_rdata=0.
- Reset mid-burst abandons the burst. No DM write occurs in the reset cycle, because dm_we is forced to 0 while reset=1.
- S_CPU:
  - CPU routed to DM; dm_we=cpu_req&cpu_we; dm_pc8=cpu_pc8; cpu_stall=0; dma_gnt=0.
  - If cpu_req=0 and dma_req=1, next state is S_DMA with beat_cnt=0. No DMA access happens in this cycle (one-cycle handover).
- S_DMA:
  - DMA routed to DM; dm_we=dma_req&dma_we; dm_pc8=0; dma_gnt=dma_req; cpu_stall=cpu_req.
  - Each beat with dma_req=1 increments beat_cnt.
  - Exit to S_CPU next cycle when dma_req=0, or when a beat is taken with beat_cnt==MAX_BURST-1.
  - After a cap exit with cpu_req=1, the CPU gets at least one cycle before DMA re-entry. This follows from CPU priority in S_CPU.
- Read data:
  - cpu_rdata=dm_rdata at all times; valid only when cpu_req=1 and cpu_stall=0.
  - On a granted DMA read beat (dma_gnt=1, dma_we=0), dma_rdata<=dm_rdata and dma_rvalid<=1 at the next edge. Otherwise dma_rvalid<=0 and dma_rdata holds its value.
- Write latency: a DM write commits at the clock edge ending the granted cycle, for both ports.
- Simultaneous events:
  - cpu_req and dma_req both high in S_CPU: CPU wins and dma_gnt=0.
  - Both high in S_DMA: DMA wins and the CPU stalls.
- Addresses pass through unmodified. Alignment is the requesters' responsibility.
- A stalled CPU must hold its req/we/addr/wdata/pc8 inputs stable. The arbiter does not latch them.

Optional Feature:
- Macro: DM_ARB_AGE_EN.
- With it defined:
  - Age counter increments each S_CPU cycle with dma_req=1 and cpu_req=1.
  - Age counter clears on S_DMA entry, when dma_req=0, and on reset.
  - When the counter reaches AGE_LIMIT, the next state is S_DMA even if cpu_req=1.
- Without it: no counter exists. DMA can starve indefinitely under continuous cpu_req, and AGE_LIMIT is unused.

Decomposition:
- Shared package dm_arb_pkg:
  - state encoding constants S_CPU=1'b0, S_DMA=1'b1;
  - DM word-index width constant 10 (1024 words).
- Optional sub-module dm_arb_age_ctr holds the aging counter, instantiated only under DM_ARB_AGE_EN.
- The mux and FSM stay in the top module.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, cpu_addr=0x10, cpu_wdata=0xDEADBEEF -> dm_we=1, dm_addr=0x10, dm_pc8=cpu_pc8, cpu_stall=0; the following load of 0x10 returns cpu_rdata=0xDEADBEEF.
- DMA burst: idle CPU, dma_req held for 3 write beats to 0x0/0x4/0x8 -> 1 handover cycle, then dma_gnt=1 for 3 cycles, return to S_CPU after dma_req drops.
- Burst cap: MAX_BURST=8, dma_req held high, cpu_req raised mid-burst -> exactly 8 beats granted, cpu_stall=1 during S_DMA, then the CPU access completes before any further DMA beat.
- DMA read: DM[0x20]=0x12345678, DMA read beat at 0x20 -> dma_rvalid=1 and dma_rdata=0x12345678 exactly one cycle after dma_gnt.
- Reset mid-burst: reset asserted in the 3rd DMA beat -> dm_we=0 that cycle; next cycle state=S_CPU, dma_gnt=0, dma_rvalid=0.
- Aging (DM_ARB_AGE_EN, AGE_LIMIT=4): cpu_req and dma_req continuously high -> S_DMA entered after 4 denied cycles; without the macro, dma_gnt stays 0 for 100 cycles.
